// File: rtl/mcc_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes,
// ALU operation codes, mux-select codes and the immediate-format decode.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_UTYPE    = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mcc_alu_dec.sv
// ALU operation decode from funct3/funct7b5; subtract is only honoured for
// register-register instructions since instr[30] is immediate data otherwise.
module mcc_alu_dec
  import mcc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory wait timeout and sticky fault.
// Define MCC_UTYPE_EN to add the UTYPE state for lui/auipc; otherwise they fault.
module multicycle_controller
  import mcc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       mem_req,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       fault,
  output logic [3:0] state_dbg
);

  localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_VAL = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             mem_wait;
  logic             timed_out;
  logic             branch_ok;
  logic [3:0]       alu_dec_ctrl;
  logic             mem_req_raw;
  logic             pc_write_raw;
  logic             ir_write_raw;

  mcc_alu_dec u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (op == OP_RTYPE),
    .alu_control (alu_dec_ctrl)
  );

  assign mem_wait  = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !mem_ready;
  assign timed_out = TMO_EN && mem_wait && (wait_cnt == TMO_VAL);
  assign branch_ok = (funct3[2:1] == 2'b00);

  // A completing access always wins over a timeout reached on the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      if (mem_wait && !timed_out)
        wait_cnt <= (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      case (state)
        S_FETCH: begin
          if (mem_ready)      state <= S_DECODE;
          else if (timed_out) state <= S_FAULT;
        end
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECUTER;
            OP_ITYPE:          state <= S_EXECUTEI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
`ifdef MCC_UTYPE_EN
            OP_LUI, OP_AUIPC:  state <= S_UTYPE;
`endif
            default:           state <= S_FAULT;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: begin
          if (mem_ready)      state <= S_MEMWB;
          else if (timed_out) state <= S_FAULT;
        end
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: begin
          if (mem_ready)      state <= S_FETCH;
          else if (timed_out) state <= S_FAULT;
        end
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= branch_ok ? S_FETCH : S_FAULT;
        S_JAL:      state <= S_ALUWB;
`ifdef MCC_UTYPE_EN
        S_UTYPE:    state <= S_ALUWB;
`endif
        default:    state <= S_FAULT;
      endcase
    end
  end

  always_comb begin
    mem_req_raw  = 1'b0;
    pc_write_raw = 1'b0;
    ir_write_raw = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REG;
    ResultSrc    = RES_ALUOUT;
    ALUControl   = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req_raw  = 1'b1;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        AdrSrc      = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_raw = 1'b1;
        AdrSrc      = 1'b1;
        MemWrite    = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_REG;
        ALUControl = alu_dec_ctrl;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec_ctrl;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA      = SRCA_REG;
        ALUControl   = ALU_SUB;
        pc_write_raw = branch_ok && (Zero ^ funct3[0]);
      end
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
`ifdef MCC_UTYPE_EN
      S_UTYPE: begin
        ALUSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
`endif
      default: ;
    endcase
  end

  // Reset must silence memory and PC/IR strobes even while FETCH is forced.
  assign mem_req   = mem_req_raw & reset;
  assign PCWrite   = pc_write_raw & reset;
  assign IRWrite   = ir_write_raw & reset;
  assign ImmSrc    = imm_sel(op);
  assign fault     = (state == S_FAULT);
  assign state_dbg = state;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max consecutive wait cycles in one memory state; 0 disables the timeout.
REQ-002 Parameter TMO_W, default 8: wait-counter width; MEM_TIMEOUT SHALL fit in TMO_W bits.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op  in  7  instruction opcode; funct3  in  3; funct7b5  in  1  instr[30].
REQ-006 Zero  in  1  ALU zero flag; mem_ready  in  1  memory completes the current access this cycle.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, mem_req  out  1 each  datapath strobes/selects.
REQ-008 ALUSrcA, ALUSrcB, ResultSrc  out  2 each; ImmSrc  out  3; ALUControl  out  4.
REQ-009 fault  out  1  sticky error; state_dbg  out  4  current state encoding.

Function
REQ-010 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, UTYPE, FAULT; all outputs not listed per state SHALL be 0.
REQ-011 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10; IRWrite=PCWrite=mem_ready; on mem_ready go DECODE, else stay.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01, add; next by op: lw/sw->MEMADR, R->EXECUTER, I-ALU->EXECUTEI, branch->BRANCH, jal->JAL, lui/auipc->UTYPE, any other op->FAULT.
REQ-013 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0->MEMREAD, 1->MEMWRITE.
REQ-014 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; on mem_ready ->MEMWB, else stay. MEMWB: ResultSrc=01, RegWrite=1 ->FETCH.
REQ-015 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, ResultSrc=00; on mem_ready ->FETCH; MemWrite held every wait cycle.
REQ-016 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01; both ALU-decoded, ->ALUWB. ALUWB: ResultSrc=00, RegWrite=1 ->FETCH.
REQ-017 ALU decode: funct3 000 add (sub only if R-type and funct7b5=1), 001 sll, 010 slt, 100 xor, 101 srl/sra by funct7b5, 110 or, 111 and; 011 ->add.
REQ-018 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite = Zero XOR funct3[0] (beq/bne); other funct3 ->FAULT; else ->FETCH.
REQ-019 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 ->ALUWB.
REQ-020 ImmSrc combinational from op in every state: I 000, S 001, B 010, J 011, U 100.
REQ-021 Wait counter clears on entering FETCH/MEMREAD/MEMWRITE, increments each cycle there with mem_ready=0, saturates; counter==MEM_TIMEOUT (MEM_TIMEOUT!=0) with mem_ready=0 ->FAULT next cycle.
REQ-022 mem_ready=1 on the same cycle the count hits MEM_TIMEOUT SHALL complete the access, not fault.
REQ-023 FAULT: fault=1, all strobes 0, mem_req=0; held until reset.

Reset
REQ-024 reset=0 SHALL immediately force FETCH, counter 0, fault 0, and gate mem_req, PCWrite, IRWrite to 0 while asserted.
REQ-025 Reset mid-access SHALL abandon it; first mem_req after release is a FETCH.

Configuration
REQ-026 Macro MCC_UTYPE_EN defined: UTYPE state, lui ALUSrcA=11 (zero), auipc ALUSrcA=01, ALUSrcB=01, add, ->ALUWB.
REQ-027 MCC_UTYPE_EN undefined: UTYPE absent; lui/auipc in DECODE ->FAULT.

Structure
REQ-028 Package mcc_pkg holds state enum, opcode constants, ALUControl codes (add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000), mux-select codes.
REQ-029 ALU decode in sub-module mcc_alu_dec; FSM, counter, output decode in top.

Verification
REQ-030 lw (op 0000011), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in MEMWB; 5 cycles.
REQ-031 sw, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-032 beq with Zero=1 -> PCWrite=1 in BRANCH; bne (funct3 001) with Zero=1 -> PCWrite=0.
REQ-033 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT after 5 cycles in FETCH, fault=1 until reset=0.
REQ-034 op 1111111 -> FAULT after DECODE; lui -> ALUWB with MCC_UTYPE_EN, FAULT without.
REQ-035 reset=0 asserted during MEMREAD wait -> state_dbg=FETCH, mem_req=0 same cycle.
